// File: rtl/ls1u_uart_dport_if.sv
// rtl/ls1u_uart_dport_if.sv - CPU data-port bus bundle for the UART responder
interface ls1u_uart_dport_if;
  logic       sel;
  logic [1:0] addr;
  logic       dread;
  logic       dwrite;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wait_o;
  logic       irq;

  modport master (
    output sel, addr, dread, dwrite, wdata,
    input  rdata, wait_o, irq
  );

  modport slave (
    input  sel, addr, dread, dwrite, wdata,
    output rdata, wait_o, irq
  );
endinterface

// File: rtl/ls1u_uart_dport.sv
// rtl/ls1u_uart_dport.sv - 8N1 UART responder on the LS1u CPU data port with TX/RX FIFOs
module ls1u_uart_dport #(
  parameter logic [15:0] CLK_DIV_DEFAULT = 16'd433,
  parameter int unsigned FIFO_AWIDTH     = 3
) (
  input  logic             clk,
  input  logic             rstn,
  ls1u_uart_dport_if.slave bus,
  input  logic             uart_rx,
  output logic             uart_tx
);
  localparam int unsigned   DEPTH   = 1 << FIFO_AWIDTH;
  localparam int unsigned   PW      = FIFO_AWIDTH + 1;
  localparam logic [15:0]   DIV_MIN = 16'd15;
  localparam logic [PW-1:0] PTR_ONE = {{FIFO_AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [15:0]   r_div;
  logic [15:0]   w_div_wr;
  logic          r_overrun;
  logic          r_frame_err;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [PW-1:0] r_tx_wptr;
  logic [PW-1:0] r_tx_rptr;
  state_t        r_tx_state;
  state_t        w_tx_state_n;
  logic [15:0]   r_tx_div;
  logic [15:0]   r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic          r_tx_line;
  logic          w_tx_line_n;
  logic          w_tx_load;
  logic          w_tx_pop;
  logic          w_tx_done;
  logic          w_tx_more;
  logic [7:0]    w_tx_head;

  logic [7:0]    r_rx_mem [DEPTH];
  logic [PW-1:0] r_rx_wptr;
  logic [PW-1:0] r_rx_rptr;
  state_t        r_rx_state;
  state_t        w_rx_state_n;
  logic [15:0]   r_rx_div;
  logic [15:0]   r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  logic          w_rx_fall;
  logic          w_rx_mid;
  logic          w_rx_end;
  logic          w_rx_load;
  logic          w_rx_clr;
  logic          w_rx_shift_en;
  logic          w_rx_push;
  logic          w_ovr_set;
  logic          w_ferr_set;

  logic          w_wr;
  logic          w_rd;
  logic          w_tx_empty;
  logic          w_tx_full;
  logic          w_tx_push;
  logic          w_tx_idle;
  logic          w_rx_nempty;
  logic          w_rx_full;
  logic          w_rx_pop;
  logic          w_stat_rd;
  logic [7:0]    w_status;
  logic [7:0]    w_rdata;

  // A simultaneous read+write is treated as a write only.
  assign w_wr        = bus.sel & bus.dwrite;
  assign w_rd        = bus.sel & bus.dread & ~bus.dwrite;

  assign w_tx_empty  = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full   = (r_tx_wptr[PW-1] != r_tx_rptr[PW-1]) &&
                       (r_tx_wptr[FIFO_AWIDTH-1:0] == r_tx_rptr[FIFO_AWIDTH-1:0]);
  assign w_rx_nempty = (r_rx_wptr != r_rx_rptr);
  assign w_rx_full   = (r_rx_wptr[PW-1] != r_rx_rptr[PW-1]) &&
                       (r_rx_wptr[FIFO_AWIDTH-1:0] == r_rx_rptr[FIFO_AWIDTH-1:0]);

  assign w_tx_push   = w_wr & (bus.addr == 2'd0) & ~w_tx_full;
  assign w_rx_pop    = w_rd & (bus.addr == 2'd0) & w_rx_nempty;
  assign w_stat_rd   = w_rd & (bus.addr == 2'd1);
  assign w_tx_idle   = w_tx_empty & (r_tx_state == ST_IDLE);
  assign w_status    = {3'b000, r_frame_err, r_overrun, w_tx_idle, w_tx_full, w_rx_nempty};

  assign bus.wait_o  = w_wr & (bus.addr == 2'd0) & w_tx_full;
  assign bus.irq     = w_rx_nempty | r_overrun | r_frame_err;
  assign bus.rdata   = w_rdata;
  assign uart_tx     = r_tx_line;

  // Combinational read mux; zero unless the CPU is reading this peripheral.
  always_comb begin
    w_rdata = 8'h00;
    if (bus.sel && bus.dread) begin
      case (bus.addr)
        2'd0:    w_rdata = w_rx_nempty ? r_rx_mem[r_rx_rptr[FIFO_AWIDTH-1:0]] : 8'h00;
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = r_div[7:0];
        default: w_rdata = r_div[15:8];
      endcase
    end
  end

  // Merge the written byte into the divider and clamp it to the shortest usable bit period.
  always_comb begin
    w_div_wr = {bus.wdata, r_div[7:0]};
    if (bus.addr == 2'd2) begin
      w_div_wr = {r_div[15:8], bus.wdata};
    end
    if (w_div_wr < DIV_MIN) begin
      w_div_wr = DIV_MIN;
    end
  end

  // Divider register and sticky error flags; a new error wins over a clearing STATUS read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div       <= CLK_DIV_DEFAULT;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr && bus.addr[1]) begin
        r_div <= w_div_wr;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (w_stat_rd) begin
        r_overrun <= 1'b0;
      end
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (w_stat_rd) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[FIFO_AWIDTH-1:0]] <= bus.wdata;
    end
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr[FIFO_AWIDTH-1:0]] <= r_rx_shift;
    end
  end

  // FIFO pointers; push and pop on the same edge both take effect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
    end
  end

  // The byte being sent stays at the TX FIFO head until its stop bit ends,
  // so the FIFO slot is only released once the frame has left the line.
  assign w_tx_head = r_tx_mem[r_tx_rptr[FIFO_AWIDTH-1:0]];
  assign w_tx_done = (r_tx_cnt == r_tx_div);
  assign w_tx_more = ((r_tx_rptr + PTR_ONE) != r_tx_wptr);

  // TX next state and the line level for the next cycle.
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_load    = 1'b0;
    w_tx_pop     = 1'b0;
    w_tx_line_n  = 1'b1;
    case (r_tx_state)
      ST_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_state_n = ST_START;
          w_tx_load    = 1'b1;
        end
      end
      ST_START: begin
        w_tx_line_n = 1'b0;
        if (w_tx_done) w_tx_state_n = ST_DATA;
      end
      ST_DATA: begin
        w_tx_line_n = w_tx_head[r_tx_bit];
        if (w_tx_done && (r_tx_bit == 3'd7)) w_tx_state_n = ST_STOP;
      end
      default: begin
        if (w_tx_done) begin
          w_tx_pop = 1'b1;
          if (w_tx_more) begin
            w_tx_state_n = ST_START;
            w_tx_load    = 1'b1;
          end else begin
            w_tx_state_n = ST_IDLE;
          end
        end
      end
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_tx_state <= ST_IDLE;
    else       r_tx_state <= w_tx_state_n;
  end

  // TX bit timer, bit index and registered line; the divider is latched per frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_cnt  <= '0;
      r_tx_div  <= CLK_DIV_DEFAULT;
      r_tx_bit  <= '0;
      r_tx_line <= 1'b1;
    end else begin
      r_tx_line <= w_tx_line_n;
      if (w_tx_load) begin
        r_tx_cnt <= '0;
        r_tx_div <= r_div;
        r_tx_bit <= '0;
      end else if (r_tx_state != ST_IDLE) begin
        if (w_tx_done) begin
          r_tx_cnt <= '0;
          if (r_tx_state == ST_DATA) r_tx_bit <= r_tx_bit + 3'd1;
        end else begin
          r_tx_cnt <= r_tx_cnt + 16'd1;
        end
      end
    end
  end

  // Two-flop synchroniser on the pin plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_mid  = (r_rx_cnt == {1'b0, r_rx_div[15:1]});
  assign w_rx_end  = (r_rx_cnt == r_rx_div);

  // RX next state and sampling decisions.
  always_comb begin
    w_rx_state_n  = r_rx_state;
    w_rx_load     = 1'b0;
    w_rx_clr      = 1'b0;
    w_rx_shift_en = 1'b0;
    w_rx_push     = 1'b0;
    w_ovr_set     = 1'b0;
    w_ferr_set    = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_n = ST_START;
          w_rx_load    = 1'b1;
        end
      end
      ST_START: begin
        if (w_rx_mid) begin
          w_rx_clr     = 1'b1;
          w_rx_state_n = r_rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_end) begin
          w_rx_clr      = 1'b1;
          w_rx_shift_en = 1'b1;
          if (r_rx_bit == 3'd7) w_rx_state_n = ST_STOP;
        end
      end
      default: begin
        if (w_rx_end) begin
          w_rx_clr     = 1'b1;
          w_rx_state_n = ST_IDLE;
          if (!r_rx_s2)       w_ferr_set = 1'b1;
          else if (w_rx_full) w_ovr_set  = 1'b1;
          else                w_rx_push  = 1'b1;
        end
      end
    endcase
  end

  // RX state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rx_state <= ST_IDLE;
    else       r_rx_state <= w_rx_state_n;
  end

  // RX bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_cnt   <= '0;
      r_rx_div   <= CLK_DIV_DEFAULT;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      if (w_rx_load) begin
        r_rx_cnt <= '0;
        r_rx_div <= r_div;
        r_rx_bit <= '0;
      end else if (w_rx_clr) begin
        r_rx_cnt <= '0;
      end else if (r_rx_state != ST_IDLE) begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
      if (w_rx_shift_en) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_ls1u_uart_dport.sv
// tb/tb_ls1u_uart_dport.sv - directed self-checking bench for ls1u_uart_dport
module tb_ls1u_uart_dport;
  logic clk = 1'b0;
  logic rstn;
  logic uart_rx;
  logic uart_tx;
  int   checks = 0;
  int   errors = 0;

  ls1u_uart_dport_if bus ();

  ls1u_uart_dport #(
    .CLK_DIV_DEFAULT(16'd433),
    .FIFO_AWIDTH    (3)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    bus.sel = 1'b1; bus.dwrite = 1'b1; bus.dread = 1'b0; bus.addr = a; bus.wdata = d;
    #1;
    while (bus.wait_o === 1'b1 && waits < 4000) begin
      @(negedge clk); #1;
      waits++;
    end
    checks++;
    if (bus.wait_o !== 1'b0) begin
      errors++;
      $display("FAIL write_wait_bound got wait_o=%b want 0", bus.wait_o);
    end
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.dwrite = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.dread = 1'b1; bus.dwrite = 1'b0; bus.addr = a;
    #1;
    d = bus.rdata;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.dread = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int w;
    int hi;
    checks++;
    if (uart_tx !== 1'b1 || bus.wait_o !== 1'b0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got tx=%b wait=%b irq=%b want 1 0 0", uart_tx, bus.wait_o, bus.irq);
    end
    @(negedge clk); rstn = 1'b1;
    cpu_write(2'd0, 8'h00, w);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_start_bit got %b want 0", uart_tx);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || bus.wait_o !== 1'b0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got tx=%b wait=%b irq=%b want 1 0 0", uart_tx, bus.wait_o, bus.irq);
    end
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    hi = 1;
    repeat (50) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) hi = 0;
    end
    checks++;
    if (hi != 1) begin
      errors++;
      $display("FAIL frame_abandoned got low_seen want tx held 1");
    end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL reset_status got %h want 04", d); end
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'hB1) begin errors++; $display("FAIL reset_divl got %h want b1", d); end
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL reset_divh got %h want 01", d); end
  endtask

  task automatic test_divider();
    logic [7:0] d;
    int w;
    cpu_write(2'd3, 8'h00, w);
    cpu_write(2'd2, 8'h05, w);
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'h0F) begin errors++; $display("FAIL div_clamp_lo got %h want 0f", d); end
    cpu_write(2'd3, 8'h12, w);
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h12) begin errors++; $display("FAIL divh_rw got %h want 12", d); end
    cpu_write(2'd3, 8'h00, w);
    cpu_read(2'd3, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL divh_back got %h want 00", d); end
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'h0F) begin errors++; $display("FAIL divl_keep got %h want 0f", d); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] bits;
    logic [7:0] d;
    int bad;
    bits = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    bus.sel = 1'b1; bus.dwrite = 1'b1; bus.addr = 2'd0; bus.wdata = 8'hA5;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.dwrite = 1'b0;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_push_edge got %b want 1", uart_tx); end
    @(posedge clk); #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_push_plus1 got %b want 1", uart_tx); end
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        @(posedge clk); #1;
        if (uart_tx !== bits[k]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL tx_bit_%0d got %0d wrong cycles want %b for 16 cycles", k, bad, bits[k]);
      end
    end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL tx_idle_after got %h want 04", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [9] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h96};
    logic [7:0] d;
    int waits [9];
    fork
      begin
        for (int i = 0; i < 9; i++) cpu_write(2'd0, exp[i], waits[i]);
      end
      begin
        int n;
        logic [9:0] fr;
        n = 0;
        while (uart_tx === 1'b1 && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        checks++;
        if (uart_tx !== 1'b0) begin
          errors++;
          $display("FAIL b2b_start got %b want 0 within 200 cycles", uart_tx);
        end else begin
          repeat (7) @(posedge clk);
          #1;
          for (int f = 0; f < 9; f++) begin
            for (int k = 0; k < 10; k++) begin
              fr[k] = uart_tx;
              repeat (16) @(posedge clk);
              #1;
            end
            checks++;
            if (fr !== {1'b1, exp[f], 1'b0}) begin
              errors++;
              $display("FAIL b2b_frame_%0d got %b want %b", f, fr, {1'b1, exp[f], 1'b0});
            end
          end
        end
      end
    join
    checks++;
    if (waits[7] != 0) begin errors++; $display("FAIL b2b_eighth_wait got %0d want 0", waits[7]); end
    checks++;
    if (waits[8] != 154) begin errors++; $display("FAIL b2b_ninth_wait got %0d want 154", waits[8]); end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL b2b_status got %h want 04", d); end
  endtask

  task automatic test_rx_byte();
    logic [7:0] d;
    send_byte(8'h3C, 1'b1);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL rx_irq got %b want 1", bus.irq); end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL rx_status got %h want 05", d); end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL rx_data got %h want 3c", d); end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rx_empty_read got %h want 00", d); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear got %b want 0", bus.irq); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    send_byte(8'h55, 1'b0);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL ferr_irq got %b want 1", bus.irq); end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h14) begin errors++; $display("FAIL ferr_status got %h want 14", d); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL ferr_irq_drop got %b want 0", bus.irq); end
    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h04 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored got status=%h irq=%b want 04 0", d, bus.irq);
    end
    send_byte(8'h81, 1'b1);
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL rx_after_glitch got %h want 81", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic [7:0] d1;
    for (int i = 0; i < 9; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL ovr_irq got %b want 1", bus.irq); end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h0D) begin errors++; $display("FAIL ovr_status got %h want 0d", d); end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL ovr_cleared got %h want 05", d); end
    for (int i = 0; i < 8; i++) begin
      cpu_read(2'd0, d);
      checks++;
      if (d !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("FAIL ovr_pop_%0d got %h want %h", i, d, 8'hA0 + 8'(i));
      end
    end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovr_drained got %h want 00", d); end
    send_byte(8'h5A, 1'b1);
    fork
      send_byte(8'hC7, 1'b1);
      begin
        @(negedge clk);
        repeat (153) @(negedge clk);
        cpu_read(2'd0, d1);
      end
    join
    checks++;
    if (d1 !== 8'h5A) begin errors++; $display("FAIL same_cycle_pop got %h want 5a", d1); end
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL same_cycle_count got %h want 05", d); end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'hC7) begin errors++; $display("FAIL same_cycle_push got %h want c7", d); end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL same_cycle_empty got %h want 00", d); end
  endtask

  initial begin
    rstn = 1'b0;
    uart_rx = 1'b1;
    bus.sel = 1'b0; bus.dread = 1'b0; bus.dwrite = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_divider();
    test_tx_frame();
    test_back_to_back();
    test_rx_byte();
    test_frame_err();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
